// File: rtl/speedtest_pkg.sv
// Shared constants for the speed-test sequencer: geometry, counter widths,
// record layout and FSM state encodings.
package speedtest_pkg;

  localparam int N_CH        = 64;
  localparam int WORD_W      = 32;
  localparam int CNT_W       = 16;
  localparam int STABLE_N    = 8;

  localparam int N_WORDS     = N_CH / WORD_W + 1;
  localparam int TIMEOUT_BIT = WORD_W - 1;
  localparam int W_IDX_W     = $clog2(N_WORDS);
  localparam int STB_W       = $clog2(STABLE_N + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_APPLY   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_EMIT    = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Vector double-flop synchronizer for classifier outputs arriving
// asynchronously to clk.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/speedtest_sequencer.sv
// Trial sequencer: applies a generator vector, waits for the classifier to
// settle, then streams {timeout, latency} plus the captured decision words.
module speedtest_sequencer
  import speedtest_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_trials,
  input  logic [CNT_W-1:0]  settle_max,
  output logic              arb_load,
  output logic [CNT_W-1:0]  arb_idx,
  input  logic [N_CH-1:0]   din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   num_trials_q;
  logic [CNT_W-1:0]   settle_max_q;
  logic [CNT_W-1:0]   t;
  logic [CNT_W-1:0]   last_chg;
  logic [CNT_W-1:0]   latency;
  logic [STB_W-1:0]   stable;
  logic               timeout;
  logic [N_CH-1:0]    din_s;
  logic [N_CH-1:0]    din_prev;
  logic [N_CH-1:0]    cap;
  logic [W_IDX_W-1:0] w;

  logic [STB_W-1:0]   stable_nxt;
  logic [CNT_W-1:0]   last_chg_nxt;
  logic [CNT_W-1:0]   t_nxt;
  logic               settled;
  logic               timed_out;
  logic               last_word;

  sync_2ff #(.W(N_CH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (din_s)
  );

  // Settling detector: a change restarts the stability run and marks the
  // latency; settling takes priority over a coincident timeout.
  always_comb begin
    stable_nxt   = stable;
    last_chg_nxt = last_chg;
    if (din_s != din_prev) begin
      stable_nxt   = '0;
      last_chg_nxt = t;
    end else if (stable != STB_W'(STABLE_N)) begin
      stable_nxt = stable + 1'b1;
    end
    t_nxt     = (t == '1) ? t : t + 1'b1;
    settled   = (stable_nxt == STB_W'(STABLE_N));
    timed_out = (t_nxt == settle_max_q) || (settle_max_q == '0);
  end

  assign last_word = (w == W_IDX_W'(N_WORDS - 1));
  assign arb_load  = (state == ST_APPLY);
  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && last_word;

  always_comb begin
    out_data = '0;
    if (state == ST_EMIT) begin
      if (w == '0) begin
        out_data[CNT_W-1:0]   = latency;
        out_data[TIMEOUT_BIT] = timeout;
      end else begin
        for (int i = 1; i < N_WORDS; i++) begin
          if (w == W_IDX_W'(i)) out_data = cap[(i-1)*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      arb_idx      <= '0;
      num_trials_q <= '0;
      settle_max_q <= '0;
      t            <= '0;
      last_chg     <= '0;
      latency      <= '0;
      stable       <= '0;
      timeout      <= 1'b0;
      din_prev     <= '0;
      cap          <= '0;
      w            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_trials != '0) begin
              state        <= ST_APPLY;
              busy         <= 1'b1;
              arb_idx      <= '0;
              num_trials_q <= num_trials;
              settle_max_q <= settle_max;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          din_prev <= din_s;
          t        <= '0;
          stable   <= '0;
          last_chg <= '0;
          state    <= ST_MEASURE;
        end
        ST_MEASURE: begin
          din_prev <= din_s;
          t        <= t_nxt;
          stable   <= stable_nxt;
          last_chg <= last_chg_nxt;
          if (settled || timed_out) begin
            timeout <= !settled;
            latency <= last_chg_nxt;
            cap     <= din_s;
            w       <= '0;
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (last_word) begin
              if (arb_idx == num_trials_q - 1'b1) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                arb_idx <= arb_idx + 1'b1;
                state   <= ST_APPLY;
              end
            end else begin
              w <= w + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speedtest_sequencer.sv
// Self-checking bench for speedtest_sequencer: table of single-trial runs
// plus hand-written settling, back-pressure, start-ignore and reset sequences.
module tb_speedtest_sequencer;
  import speedtest_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_trials;
  logic [CNT_W-1:0]  settle_max;
  logic              arb_load;
  logic [CNT_W-1:0]  arb_idx;
  logic [N_CH-1:0]   din;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  typedef struct {
    logic [N_CH-1:0]   din_v;
    logic [CNT_W-1:0]  settle;
    logic [WORD_W-1:0] w0;
  } vec_t;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic              last;
  } word_t;

  vec_t  vecs[6];
  word_t exp_q[$];
  int    rd_ptr = 0;
  int    tests_run = 0;
  int    tests_failed = 0;
  int    arb_count = 0;
  int    idx_base = 0;
  int    cycle = 0;
  int    last_hs_cycle = 0;
  int    ready_mode = 0;
  logic  stall_prev = 1'b0;
  logic [WORD_W-1:0] held_data = '0;
  logic  seen;

  speedtest_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_trials (num_trials),
    .settle_max (settle_max),
    .arb_load   (arb_load),
    .arb_idx    (arb_idx),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushRecord(input logic [WORD_W-1:0] w0, input logic [N_CH-1:0] d);
    word_t e;
    e.data = w0;       e.last = 1'b0; exp_q.push_back(e);
    e.data = d[31:0];  e.last = 1'b0; exp_q.push_back(e);
    e.data = d[63:32]; e.last = 1'b1; exp_q.push_back(e);
  endtask

  // Returns at the negedge right after the start pulse is accepted.
  task automatic applyStimulus(input logic [N_CH-1:0] d, input logic [CNT_W-1:0] nt,
                               input logic [CNT_W-1:0] sm);
    din        = d;
    num_trials = nt;
    settle_max = sm;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finishRun(input logic got);
    checkOutput("done_seen", 64'(got), 64'd1);
    if (got) begin
      checkOutput("busy_at_done", 64'(busy), 64'd0);
      checkOutput("done_latency", 64'(cycle - last_hs_cycle), 64'd1);
      checkOutput("words_pending", 64'(exp_q.size() - rd_ptr), 64'd0);
      @(negedge clk);
      checkOutput("done_width", 64'(done), 64'd0);
    end
  endtask

  task automatic waitDone(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    finishRun(got);
  endtask

  task automatic waitValid(input int budget);
    logic got;
    got = out_valid;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    checkOutput("valid_seen", 64'(got), 64'd1);
  endtask

  // Consumer-ready driver, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 99) < 30);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: compares every accepted word, checks held words
  // under back-pressure and the arb_idx sequence; reset abandons pending words.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_ptr     = exp_q.size();
        stall_prev = 1'b0;
      end else begin
        if (arb_load) begin
          checkOutput("arb_idx", 64'(arb_idx), 64'(arb_count - idx_base));
          arb_count++;
        end
        if (stall_prev) begin
          checkOutput("hold_valid", 64'(out_valid), 64'd1);
          checkOutput("hold_data", 64'(out_data), 64'(held_data));
        end
        if (out_valid && out_ready) begin
          if (rd_ptr < exp_q.size()) begin
            checkOutput("word_data", 64'(out_data), 64'(exp_q[rd_ptr].data));
            checkOutput("word_last", 64'(out_last), 64'(exp_q[rd_ptr].last));
            rd_ptr++;
          end else begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", out_data);
          end
          if (out_last) last_hs_cycle = cycle;
        end
        stall_prev = out_valid && !out_ready;
        held_data  = out_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{din_v: 64'h0,                  settle: 16'd100,    w0: 32'h0000_0000};
    vecs[1] = '{din_v: 64'hDEADBEEF_CAFEF00D,  settle: 16'd100,    w0: 32'h0000_0000};
    vecs[2] = '{din_v: 64'h80000000_00000001,  settle: 16'd0,      w0: 32'h8000_0000};
    vecs[3] = '{din_v: 64'h55555555_55555555,  settle: 16'd7,      w0: 32'h8000_0000};
    vecs[4] = '{din_v: 64'hAAAAAAAA_AAAAAAAA,  settle: 16'd8,      w0: 32'h0000_0000};
    vecs[5] = '{din_v: 64'hFFFFFFFF_FFFFFFFF,  settle: 16'hFFFF,   w0: 32'h0000_0000};

    rst_n = 1'b0; start = 1'b0; din = '0; num_trials = '0; settle_max = '0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_arb_load", 64'(arb_load), 64'd0);
    checkOutput("rst_arb_idx", 64'(arb_idx), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Table: single-trial runs with constant inputs and timeout boundaries.
    for (int i = 0; i < 6; i++) begin
      pushRecord(vecs[i].w0, vecs[i].din_v);
      idx_base = arb_count;
      applyStimulus(vecs[i].din_v, 16'd1, vecs[i].settle);
      checkOutput("arb_load_pulse", 64'(arb_load), 64'd1);
      checkOutput("busy_in_run", 64'(busy), 64'd1);
      waitDone(200);
    end

    // Bit 5 changes at t=3 and t=10, then holds.
    pushRecord(32'h0000_000A, 64'h20);
    idx_base = arb_count;
    applyStimulus(64'h20, 16'd1, 16'd100);
    checkOutput("arb_load_settle", 64'(arb_load), 64'd1);
    repeat (2) @(negedge clk);
    din = 64'h0;
    repeat (7) @(negedge clk);
    din = 64'h20;
    waitDone(200);

    // Input toggles every cycle until timeout at settle_max=20.
    din = 64'h01234567_89ABCDEF;
    num_trials = 16'd1;
    settle_max = 16'd20;
    repeat (4) @(negedge clk);
    pushRecord(32'h8000_0013, ~64'h01234567_89ABCDEF);
    idx_base = arb_count;
    seen = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      din   = ~din;
      start = (j == 3);
    end
    start = 1'b0;
    finishRun(seen);

    // Four trials under random back-pressure.
    for (int k = 0; k < 4; k++) pushRecord(32'h0, 64'hA5A50F0F_12348765);
    idx_base = arb_count;
    ready_mode = 1;
    applyStimulus(64'hA5A50F0F_12348765, 16'd4, 16'd100);
    waitDone(3000);
    checkOutput("multi_arb_loads", 64'(arb_count - idx_base), 64'd4);
    ready_mode = 0;

    // Zero-trial start: only a done pulse.
    idx_base = arb_count;
    applyStimulus(64'h0, 16'd0, 16'd100);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("zero_done_width", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("zero_busy_later", 64'(busy), 64'd0);
    checkOutput("zero_arb_loads", 64'(arb_count - idx_base), 64'd0);

    // Start while busy is ignored.
    ready_mode = 2;
    pushRecord(32'h0, 64'h13572468_0000FFFF);
    idx_base = arb_count;
    applyStimulus(64'h13572468_0000FFFF, 16'd1, 16'd100);
    waitValid(100);
    @(negedge clk);
    num_trials = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_held", 64'(busy), 64'd1);
    ready_mode = 0;
    waitDone(200);
    repeat (10) @(negedge clk);
    checkOutput("ignored_arb_loads", 64'(arb_count - idx_base), 64'd1);
    checkOutput("ignored_busy", 64'(busy), 64'd0);

    // Reset during EMIT of the second trial.
    pushRecord(32'h0, 64'h0F0F0F0F_F0F0F0F0);
    pushRecord(32'h0, 64'h0F0F0F0F_F0F0F0F0);
    idx_base = arb_count;
    applyStimulus(64'h0F0F0F0F_F0F0F0F0, 16'd2, 16'd100);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (arb_idx == 16'd1);
    end
    checkOutput("second_trial_seen", 64'(seen), 64'd1);
    ready_mode = 2;
    waitValid(100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_data", 64'(out_data), 64'd0);
    checkOutput("mid_rst_last", 64'(out_last), 64'd0);
    checkOutput("mid_rst_idx", 64'(arb_idx), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ready_mode = 0;

    pushRecord(32'h0, 64'h0);
    idx_base = arb_count;
    applyStimulus(64'h0, 16'd1, 16'd100);
    checkOutput("post_rst_arb_load", 64'(arb_load), 64'd1);
    waitDone(200);
    checkOutput("post_rst_arb_loads", 64'(arb_count - idx_base), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/speedtest_sequencer.md
Name: speedtest_sequencer

Overview:
- Digital controller for the 350 nm speed-test system: arbitrary-voltage generator → 64x64 classifier → 64-channel digital readout.
- Per trial: commands the generator to apply vector index k, then watches the 64 classifier output bits for settling.
- Records the settling latency and the final 64-bit decision, then streams the result as 32-bit words over a valid/ready interface toward the readout host.
- Repeats for a programmed number of trials.

Parameters:
- N_CH, 64, classifier output / readout input channels; must be a multiple of WORD_W.
- WORD_W, 32, output word width.
- CNT_W, 16, width of trial index, settle timeout and latency counters.
- STABLE_N, 8, consecutive unchanged cycles that declare outputs settled (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- num_trials  in  CNT_W  trials per run; sampled on accepted start.
- settle_max  in  CNT_W  timeout in cycles; sampled on accepted start.
- arb_load  out  1  one-cycle pulse: generator applies vector arb_idx.
- arb_idx  out  CNT_W  current vector/trial index.
- din  in  N_CH  raw classifier outputs (asynchronous to clk).
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer ready.
- out_data  out  WORD_W  result word.
- out_last  out  1  marks final word of a trial record.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word of the run is accepted.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. arb_load=0, arb_idx=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Counters and capture registers=0. Reset mid-run abandons the run; no partial record completes.
- din passes through a 2-flop synchronizer, giving din_s with 2 cycles of latency. All comparisons use din_s.
- IDLE:
  - start && num_trials≠0 → APPLY; latch config; busy=1; arb_idx=0.
  - start && num_trials==0 → done pulses next cycle; busy stays 0.
  - start while busy is ignored.
- APPLY (1 cycle): arb_load=1; din_prev←din_s; t=0, stable=0, last_chg=0 → MEASURE.
- MEASURE, each cycle:
  - If din_s≠din_prev: stable←0, last_chg←t.
  - Else: stable←stable+1, saturating at STABLE_N.
  - Always: din_prev←din_s; t←t+1.
  - Exit when updated stable==STABLE_N: timeout=0, latency=last_chg.
  - Otherwise exit when t==settle_max: timeout=1, latency=last_chg.
  - settle_max=0 → timeout immediately after the first MEASURE cycle.
  - On exit: cap←din_s → EMIT with word index w=0.
- EMIT: record of 1+N_CH/WORD_W words, each held stable until out_valid&&out_ready.
  - w=0: {timeout, zeros, latency[CNT_W-1:0]}.
  - w=1..N_CH/WORD_W: cap[(w-1)*WORD_W +: WORD_W], LSB chunk first.
  - out_last=1 on the final word only.
- On final handshake:
  - If arb_idx==num_trials-1 → IDLE; done=1 for one cycle; busy=0 that same cycle.
  - Else arb_idx+1 → APPLY.
- Back-pressure: out_ready low stalls indefinitely. No word is dropped or duplicated. out_valid never deasserts without a handshake.
- Counter t saturates at 2^CNT_W−1 and never wraps. Effective timeout is min(settle_max, 2^CNT_W−1).

Decomposition:
- speedtest_pkg:
  - state enum {IDLE, APPLY, MEASURE, EMIT}.
  - localparam N_WORDS = N_CH/WORD_W + 1.
  - Latency-word bit positions (TIMEOUT_BIT = WORD_W-1).
- Sub-module sync_2ff (parameter W): vector double-flop synchronizer with the same clk/rst_n; reset value 0.

Test Plan:
1. num_trials=1, settle_max=100, din constant 0x0 → one arb_load, then 3 words 0x00000000, 0x0, 0x0 (last on word 2); done 1 cycle after the final handshake.
2. din toggles bit 5 at MEASURE t=3 and t=10, then holds → latency word 0x0000000A, timeout=0; data words 0x00000020, 0x0.
3. din toggles every cycle, settle_max=20 → word0 = 0x80000000|last_chg (≤19); record still emitted.
4. num_trials=4, out_ready random 30% → arb_idx 0,1,2,3 in order; 12 words; no loss or duplication; out_last on words 2,5,8,11.
5. num_trials=0 start → done pulse, busy never high, no arb_load. start pulsed during busy → ignored.
6. rst_n asserted mid-EMIT with out_valid=1 → outputs zero immediately. After release, a fresh start behaves as in scenario 1.
